// File: rtl/fp_divider_if.sv
// Handshake and operand/result bundle for the sequential FP divider.
interface fp_divider_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] c;

    modport master (output start, a, b, input busy, done, c);
    modport slave  (input start, a, b, output busy, done, c);
endinterface

// File: rtl/fp_divider.sv
// Sequential single-precision divider: restoring shift-subtract mantissa loop
// (one quotient bit per cycle), truncation rounding, no NaN/Inf decoding.
module fp_divider (
    input  logic         clk_i,
    input  logic         reset_ni,
    fp_divider_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t              state_q;
    logic                busy_q;
    logic                done_q;
    logic [31:0]         c_q;
    logic                sign_q;
    logic [7:0]          ea_q;
    logic [7:0]          eb_q;
    logic [23:0]         mb_q;
    logic [24:0]         rem_q;
    logic [24:0]         quo_q;
    logic [4:0]          cnt_q;
    logic                force_q;
    logic [31:0]         force_val_q;

    logic                ge_s;
    logic [24:0]         rem_sub_s;
    logic [24:0]         rem_d;
    logic [24:0]         quo_d;
    logic signed [9:0]   exp_s;
    logic [22:0]         frac_s;
    logic [31:0]         res_d;
    logic                in_sign_s;
    logic                in_a_zero_s;
    logic                in_b_zero_s;
    logic                in_special_s;
    logic [31:0]         in_force_s;

    // Operand decode of the bus for the special-case shortcut taken in IDLE.
    always_comb begin
        in_sign_s    = bus.a[31] ^ bus.b[31];
        in_a_zero_s  = (bus.a[30:23] == 8'h00);
        in_b_zero_s  = (bus.b[30:23] == 8'h00);
        in_special_s = in_a_zero_s | in_b_zero_s;
        if (in_b_zero_s && in_a_zero_s) begin
            in_force_s = 32'h7FC0_0000;
        end else if (in_b_zero_s) begin
            in_force_s = {in_sign_s, 8'hFF, 23'h0};
        end else begin
            in_force_s = {in_sign_s, 31'h0};
        end
    end

    // One restoring-division step plus normalisation of the finished quotient.
    always_comb begin
        ge_s      = (rem_q >= {1'b0, mb_q});
        rem_sub_s = ge_s ? (rem_q - {1'b0, mb_q}) : rem_q;
        rem_d     = rem_sub_s << 1;
        quo_d     = {quo_q[23:0], ge_s};
        exp_s     = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
                  + (quo_q[24] ? 10'sd127 : 10'sd126);
        frac_s    = quo_q[24] ? quo_q[23:1] : quo_q[22:0];
        if (force_q) begin
            res_d = force_val_q;
        end else if (exp_s >= 10'sd255) begin
            res_d = {sign_q, 8'hFF, 23'h0};
        end else if (exp_s <= 10'sd0) begin
            res_d = {sign_q, 31'h0};
        end else begin
            res_d = {sign_q, exp_s[7:0], frac_s};
        end
    end

    // Control FSM and datapath registers; outputs are registered here.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            c_q         <= 32'h0;
            sign_q      <= 1'b0;
            ea_q        <= 8'h00;
            eb_q        <= 8'h00;
            mb_q        <= 24'h0;
            rem_q       <= 25'h0;
            quo_q       <= 25'h0;
            cnt_q       <= 5'd0;
            force_q     <= 1'b0;
            force_val_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        busy_q      <= 1'b1;
                        sign_q      <= in_sign_s;
                        ea_q        <= bus.a[30:23];
                        eb_q        <= bus.b[30:23];
                        mb_q        <= {1'b1, bus.b[22:0]};
                        rem_q       <= {2'b01, bus.a[22:0]};
                        quo_q       <= 25'h0;
                        cnt_q       <= 5'd0;
                        force_q     <= in_special_s;
                        force_val_q <= in_force_s;
                        state_q     <= in_special_s ? NORM : DIV;
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd24) begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    c_q     <= res_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.c    = c_q;

endmodule
